// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit game: sequencer states, screen limits,
// LFSR configuration and the blade/fruit distance helper.
package fruit_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSpawn,
        StFly,
        StCut,
        StGameOver
    } state_t;

    localparam logic [7:0]  StartKey  = 8'h28;
    localparam logic [15:0] LfsrSeed  = 16'hACE1;
    // Taps 16,14,13,11 as a mask over state bits 15,13,12,10.
    localparam logic [15:0] LfsrTaps  = 16'hB400;

    localparam logic [9:0]  YMax      = 10'd479;
    localparam logic [9:0]  MissY     = YMax + 10'd1;
    localparam logic [9:0]  SpawnXMin = 10'd64;

    localparam logic [7:0]  MinAir    = 8'd8;
    localparam logic [4:0]  CutFrames = 5'd16;
    localparam logic [1:0]  LivesInit = 2'd3;

    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[10] ? (11'd0 - d) : d;
    endfunction

endpackage

// File: rtl/fruit_controller_lfsr16.sv
// 16-bit Fibonacci LFSR, advancing every clock; a non-zero seed keeps it out of
// the all-zero lock-up state.
module lfsr16
    import fruit_pkg::*;
#(
    parameter logic [15:0] Seed = LfsrSeed
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = {state_q[14:0], ^(state_q & LfsrTaps)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= Seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/fruit_controller.sv
// Per-frame game sequencer: spawns fruit, judges blade hits and misses, and keeps
// score and lives. Every output is a register loaded with the next state's value.
module fruit_controller
    import fruit_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [9:0] fruitX,
    input  logic [9:0] fruitY,
    input  logic [9:0] fruitS,
    input  logic [9:0] bladeX,
    input  logic [9:0] bladeY,
    input  logic       blade_down,
    output logic       new_fruit,
    output logic       move_fruit,
    output logic [9:0] spawn_x,
    output logic [9:0] spawn_vx,
    output logic [9:0] spawn_vy,
    output logic [7:0] number_of_fruits_cut,
    output logic [1:0] lives,
    output logic       fruit_cut,
    output logic       game_over
);

    localparam logic [3:0] CutLast = 4'(CutFrames - 5'd1);

    state_t      state_q, state_d;
    logic        new_fruit_q, new_fruit_d;
    logic        move_fruit_q, move_fruit_d;
    logic        fruit_cut_q, fruit_cut_d;
    logic        game_over_q, game_over_d;
    logic [9:0]  spawn_x_q, spawn_x_d;
    logic [9:0]  spawn_vx_q, spawn_vx_d;
    logic [9:0]  spawn_vy_q, spawn_vy_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  air_q, air_d;
    logic [3:0]  cut_q, cut_d;

    logic [15:0] lfsr;
    logic        unused_lfsr;
    logic        start, hit, miss, spawn_go;

    lfsr16 #(
        .Seed (LfsrSeed)
    ) u_lfsr (
        .clk   (frame_clk),
        .rst_n (Reset),
        .state (lfsr)
    );

    assign unused_lfsr = lfsr[9];

    assign start = (keycode == StartKey);
    assign hit   = blade_down
                   && (abs_diff(bladeX, fruitX) <= {1'b0, fruitS})
                   && (abs_diff(bladeY, fruitY) <= {1'b0, fruitS});
    assign miss  = (air_q >= MinAir) && (fruitY >= MissY);

    always_comb begin
        state_d    = state_q;
        spawn_x_d  = spawn_x_q;
        spawn_vx_d = spawn_vx_q;
        spawn_vy_d = spawn_vy_q;
        score_d    = score_q;
        lives_d    = lives_q;
        air_d      = air_q;
        cut_d      = cut_q;
        fruit_cut_d = 1'b0;
        spawn_go   = 1'b0;

        unique case (state_q)
            StIdle, StGameOver: begin
                if (start) begin
                    score_d  = 8'd0;
                    lives_d  = LivesInit;
                    spawn_go = 1'b1;
                end
            end
            StSpawn: begin
                state_d = StFly;
            end
            StFly: begin
                air_d = (air_q == 8'hFF) ? air_q : air_q + 8'd1;
                // A slice takes priority over a simultaneous miss.
                if (hit) begin
                    fruit_cut_d = 1'b1;
                    score_d     = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    cut_d       = 4'd0;
                    state_d     = StCut;
                end else if (miss) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d = StGameOver;
                    end else begin
                        spawn_go = 1'b1;
                    end
                end
            end
            StCut: begin
                if (cut_q == CutLast) begin
                    spawn_go = 1'b1;
                end else begin
                    cut_d = cut_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (spawn_go) begin
            state_d    = StSpawn;
            air_d      = 8'd0;
            spawn_x_d  = SpawnXMin + {1'b0, lfsr[8:0]};
            spawn_vx_d = {7'd0, lfsr[12:10]} - 10'd4;
            spawn_vy_d = 10'd0 - (10'd8 + {7'd0, lfsr[15:13]});
        end

        new_fruit_d  = (state_d == StSpawn);
        move_fruit_d = (state_d == StFly);
        game_over_d  = (state_d == StGameOver);
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state_q      <= StIdle;
            new_fruit_q  <= 1'b0;
            move_fruit_q <= 1'b0;
            fruit_cut_q  <= 1'b0;
            game_over_q  <= 1'b0;
            spawn_x_q    <= 10'd0;
            spawn_vx_q   <= 10'd0;
            spawn_vy_q   <= 10'd0;
            score_q      <= 8'd0;
            lives_q      <= LivesInit;
            air_q        <= 8'd0;
            cut_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            new_fruit_q  <= new_fruit_d;
            move_fruit_q <= move_fruit_d;
            fruit_cut_q  <= fruit_cut_d;
            game_over_q  <= game_over_d;
            spawn_x_q    <= spawn_x_d;
            spawn_vx_q   <= spawn_vx_d;
            spawn_vy_q   <= spawn_vy_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            air_q        <= air_d;
            cut_q        <= cut_d;
        end
    end

    assign new_fruit            = new_fruit_q;
    assign move_fruit           = move_fruit_q;
    assign fruit_cut            = fruit_cut_q;
    assign game_over            = game_over_q;
    assign spawn_x              = spawn_x_q;
    assign spawn_vx             = spawn_vx_q;
    assign spawn_vy             = spawn_vy_q;
    assign number_of_fruits_cut = score_q;
    assign lives                = lives_q;

endmodule

// File: tb/tb_fruit_controller.sv
// Self-checking bench for fruit_controller: directed game flow with a scoreboard of
// expected scores popped on each slice pulse and a reference LFSR for spawn values.
module tb_fruit_controller;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode;
    logic [9:0] fruitX, fruitY, fruitS, bladeX, bladeY;
    logic       blade_down;
    logic       new_fruit, move_fruit, fruit_cut, game_over;
    logic [9:0] spawn_x, spawn_vx, spawn_vy;
    logic [7:0] number_of_fruits_cut;
    logic [1:0] lives;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_score = 0;
    int score_q[$];

    logic [15:0] m_lfsr, m_prev;
    logic        nf_prev = 1'b0;

    fruit_controller dut (
        .frame_clk            (frame_clk),
        .Reset                (Reset),
        .keycode              (keycode),
        .fruitX               (fruitX),
        .fruitY               (fruitY),
        .fruitS               (fruitS),
        .bladeX               (bladeX),
        .bladeY               (bladeY),
        .blade_down           (blade_down),
        .new_fruit            (new_fruit),
        .move_fruit           (move_fruit),
        .spawn_x              (spawn_x),
        .spawn_vx             (spawn_vx),
        .spawn_vy             (spawn_vy),
        .number_of_fruits_cut (number_of_fruits_cut),
        .lives                (lives),
        .fruit_cut            (fruit_cut),
        .game_over            (game_over)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference LFSR; m_prev holds the value seen before the latest edge.
    always @(posedge frame_clk) begin
        m_lfsr <= !Reset ? 16'hACE1 : lfsr_step(m_lfsr);
        m_prev <= m_lfsr;
    end

    always @(negedge frame_clk) begin
        if (Reset === 1'b1) begin
            if (fruit_cut === 1'b1) begin
                if (score_q.size() == 0) check("cut_unexpected", 1, 0);
                else check("cut_score", int'(number_of_fruits_cut), score_q.pop_front());
            end
            if (new_fruit === 1'b1) begin
                int x, vx, vy;
                x  = int'(spawn_x);
                vx = int'($signed(spawn_vx));
                vy = int'($signed(spawn_vy));
                check("nf_pulse", int'(nf_prev), 0);
                check("spawn_x", x, 64 + int'(m_prev[8:0]));
                check("spawn_vx", vx, int'(m_prev[12:10]) - 4);
                check("spawn_vy", vy, -(8 + int'(m_prev[15:13])));
                check("spawn_rng", int'(x >= 64 && x <= 575 && vx >= -4 && vx <= 3
                                        && vy >= -15 && vy <= -8), 1);
            end
        end
        nf_prev <= new_fruit;
    end

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic wait_spawn(input string tag, input int want);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (new_fruit !== 1'b1 && n < 40);
        check(tag, n, want);
    endtask

    task automatic push_hit();
        exp_score = (exp_score < 255) ? exp_score + 1 : 255;
        score_q.push_back(exp_score);
    endtask

    // Entered at the SPAWN cycle; leaves at the next SPAWN cycle.
    task automatic do_hit();
        fruitX = 10'd300; fruitY = 10'd200; bladeX = 10'd300; bladeY = 10'd200;
        blade_down = 1'b1;
        push_hit();
        step();
        step();
        check("hit_cut", int'(fruit_cut), 1);
        blade_down = 1'b0;
        wait_spawn("hit_cut_len", 16);
    endtask

    task automatic miss_one(input int exp_lives, input bit last);
        fruitY = 10'd480;
        blade_down = 1'b0;
        step();
        repeat (3) step();
        check("miss_mask3", int'(lives), exp_lives + 1);
        repeat (5) step();
        check("miss_mask8", int'(lives), exp_lives + 1);
        check("miss_fly", int'(move_fruit), 1);
        step();
        check("miss_lives", int'(lives), exp_lives);
        check("miss_next", int'(last ? game_over : new_fruit), 1);
        fruitY = 10'd200;
    endtask

    initial begin
        Reset = 1'b0; keycode = 8'h00; blade_down = 1'b0;
        fruitX = 10'd300; fruitY = 10'd200; fruitS = 10'd4;
        bladeX = 10'd0; bladeY = 10'd0;
        step();
        step();
        Reset = 1'b1;
        check("rst_new", int'(new_fruit), 0);
        check("rst_move", int'(move_fruit), 0);
        check("rst_over", int'(game_over), 0);
        check("rst_score", int'(number_of_fruits_cut), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_spawn_x", int'(spawn_x), 0);
        repeat (3) step();
        check("idle_hold", int'(new_fruit | move_fruit), 0);

        keycode = 8'h28;
        step();
        keycode = 8'h00;
        check("start_new", int'(new_fruit), 1);
        check("start_move", int'(move_fruit), 0);
        step();
        check("start_nf_off", int'(new_fruit), 0);
        check("start_move_on", int'(move_fruit), 1);

        // Near miss by one pixel in X, with START_KEY held to show it is ignored in FLY.
        keycode = 8'h28; bladeX = 10'd305; bladeY = 10'd196; blade_down = 1'b1;
        repeat (3) step();
        check("near_cut", int'(fruit_cut), 0);
        check("near_score", int'(number_of_fruits_cut), 0);
        check("fly_key_ignored", int'(new_fruit), 0);
        check("near_move", int'(move_fruit), 1);
        keycode = 8'h00;
        bladeX = 10'd304;
        push_hit();
        step();
        check("edge_cut", int'(fruit_cut), 1);
        check("cut_move", int'(move_fruit), 0);
        blade_down = 1'b0;
        wait_spawn("cut_len", 16);

        repeat (4) do_hit();
        check("score5", int'(number_of_fruits_cut), 5);

        // Reset mid-flight with the blade on the fruit: nothing must survive it.
        step();
        Reset = 1'b0; bladeX = 10'd300; bladeY = 10'd200; blade_down = 1'b1;
        step();
        step();
        Reset = 1'b1; blade_down = 1'b0;
        exp_score = 0;
        check("mid_rst_score", int'(number_of_fruits_cut), 0);
        check("mid_rst_lives", int'(lives), 3);
        check("mid_rst_out", int'(new_fruit | move_fruit | fruit_cut), 0);
        step();
        check("mid_rst_idle", int'(new_fruit | move_fruit), 0);

        keycode = 8'h28;
        step();
        keycode = 8'h00;
        check("start2_new", int'(new_fruit), 1);
        miss_one(2, 1'b0);
        miss_one(1, 1'b0);
        miss_one(0, 1'b1);
        check("over_move", int'(move_fruit), 0);

        bladeX = 10'd300; bladeY = 10'd200; blade_down = 1'b1;
        repeat (3) step();
        check("over_hold", int'(game_over), 1);
        check("over_lives", int'(lives), 0);
        check("over_score", int'(number_of_fruits_cut), 0);
        blade_down = 1'b0;

        keycode = 8'h28;
        step();
        keycode = 8'h00;
        check("restart_new", int'(new_fruit), 1);
        check("restart_over", int'(game_over), 0);
        check("restart_lives", int'(lives), 3);
        check("restart_score", int'(number_of_fruits_cut), 0);

        // Hit and miss in the same FLY cycle (air_cnt == 8).
        fruitX = 10'd300; fruitY = 10'd480; bladeX = 10'd300; bladeY = 10'd480;
        blade_down = 1'b0;
        step();
        repeat (8) step();
        check("hm_pre_lives", int'(lives), 3);
        blade_down = 1'b1;
        push_hit();
        step();
        check("hm_cut", int'(fruit_cut), 1);
        check("hm_lives", int'(lives), 3);
        blade_down = 1'b0; fruitY = 10'd200; bladeY = 10'd200;
        wait_spawn("hm_cut_len", 16);

        repeat (254) do_hit();
        check("score255", int'(number_of_fruits_cut), 255);
        do_hit();
        check("score_sat", int'(number_of_fruits_cut), 255);

        check("sb_empty", score_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
